// File: rtl/spi_pkg.sv
// Shared SPI definitions for the LED runner's initiator and responder.
package spi_pkg;

    localparam int DEF_REG_WIDTH = 8;

    // Mode 0: sclk idles low, data sampled on the rising edge.
    localparam bit CPOL = 1'b0;
    localparam bit CPHA = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with registered
// single-cycle rise/fall pulses taken from the synchronised value.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic sys_clk,
    input  logic rstn,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // The edge pulses are registered, so they trail dout by one cycle.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
            fall   <= ~sync_q[SYNC_STAGES-1] & prev_q;
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_led_responder.sv
// SPI mode-0 responder: receives bytes on mosi into the LED register and
// returns a preloaded status byte on miso, all in the sys_clk domain.
module spi_led_responder
    import spi_pkg::*;
#(
    parameter int REG_WIDTH   = DEF_REG_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int LED_WIDTH   = 6
) (
    input  logic                 sys_clk,
    input  logic                 rstn,
    input  logic                 cs,
    input  logic                 sclk,
    input  logic                 mosi,
    output logic                 miso,
    input  logic [REG_WIDTH-1:0] tx_data,
    input  logic                 tx_load,
    output logic [REG_WIDTH-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic [LED_WIDTH-1:0] led,
    output logic [1:0]           state
);

    localparam int               CNT_W    = $clog2(REG_WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(REG_WIDTH);

    logic cs_s, cs_rise, cs_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic unused_sigs;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .sys_clk (sys_clk),
        .rstn    (rstn),
        .din     (cs),
        .dout    (cs_s),
        .rise    (cs_rise),
        .fall    (cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .sys_clk (sys_clk),
        .rstn    (rstn),
        .din     (sclk),
        .dout    (sclk_s),
        .rise    (sclk_rise),
        .fall    (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .sys_clk (sys_clk),
        .rstn    (rstn),
        .din     (mosi),
        .dout    (mosi_s),
        .rise    (mosi_rise),
        .fall    (mosi_fall)
    );

    assign unused_sigs = &{1'b0, sclk_s, mosi_rise, mosi_fall};

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [REG_WIDTH-1:0]   shift_rx_q, shift_rx_d;
    logic [REG_WIDTH-1:0]   shift_tx_q, shift_tx_d;
    logic [REG_WIDTH-1:0]   tx_hold_q;
    logic [REG_WIDTH-1:0]   rx_data_d;
    logic [LED_WIDTH-1:0]   led_d;
    logic                   rx_valid_d, frame_err_d;

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_rx_q <= '0;
            shift_tx_q <= '0;
            tx_hold_q  <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            led        <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_rx_q <= shift_rx_d;
            shift_tx_q <= shift_tx_d;
            rx_data    <= rx_data_d;
            rx_valid   <= rx_valid_d;
            frame_err  <= frame_err_d;
            led        <= led_d;
            if (tx_load) begin
                tx_hold_q <= tx_data;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_rx_d  = shift_rx_q;
        shift_tx_d  = shift_tx_q;
        rx_data_d   = rx_data;
        led_d       = led;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    shift_tx_d = tx_hold_q;
                    bit_cnt_d  = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    shift_rx_d = {shift_rx_q[REG_WIDTH-2:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                end
                // With bit_cnt at 0 the MSB of a freshly loaded byte must stay on the line.
                if (sclk_fall && bit_cnt_q != '0) begin
                    shift_tx_d = {shift_tx_q[REG_WIDTH-2:0], 1'b0};
                end
                // A completing bit wins over a simultaneous cs rise.
                if (sclk_rise && bit_cnt_d == CNT_FULL) begin
                    state_d = DONE;
                end else if (cs_rise) begin
                    frame_err_d = (bit_cnt_d != '0);
                    shift_rx_d  = '0;
                    bit_cnt_d   = '0;
                    state_d     = IDLE;
                end
            end
            DONE: begin
                rx_data_d  = shift_rx_q;
                rx_valid_d = 1'b1;
                led_d      = shift_rx_q[LED_WIDTH-1:0];
                bit_cnt_d  = '0;
                shift_tx_d = tx_hold_q;
                state_d    = cs_s ? IDLE : SHIFT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign miso  = cs_s ? 1'bz : shift_tx_q[REG_WIDTH-1];
    assign state = state_q;

endmodule

// File: doc/spi_led_responder.md
Name: spi_led_responder

Overview:
- SPI mode-0 responder (slave) for the LED runner's SPI initiator.
- Receives REG_WIDTH-bit frames MSB-first on mosi, drives led[5:0] from each received byte, and returns a preloaded status byte on miso.
- Oversamples cs/sclk/mosi in the sys_clk domain. sys_clk must be at least 4x the sclk frequency.

Parameters:
- REG_WIDTH, 8, bits per frame (shift register width).
- SYNC_STAGES, 2, synchroniser flops on cs, sclk and mosi (min 2).
- LED_WIDTH, 6, number of LED outputs driven from rx_data[LED_WIDTH-1:0].

Ports:
- sys_clk  input  1  system clock; all logic on its rising edge.
- rstn  input  1  synchronous active-low reset.
- cs  input  1  chip select from the initiator, active-low, asynchronous.
- sclk  input  1  SPI clock from the initiator, idle low, asynchronous.
- mosi  input  1  serial data in, sampled on sclk rising edge.
- miso  output  1  serial data out, changes on sclk falling edge; 1'bz while cs is high.
- tx_data  input  REG_WIDTH  byte to return in the next frame.
- tx_load  input  1  1-cycle strobe: latch tx_data into tx_hold.
- rx_data  output  REG_WIDTH  last complete received byte.
- rx_valid  output  1  1-cycle pulse when rx_data updates.
- frame_err  output  1  1-cycle pulse when cs rises mid-byte.
- led  output  LED_WIDTH  LED pattern register.

Behaviour:
- Reset (rstn low at a sys_clk edge):
  - state=IDLE, bit_cnt=0, shift_rx=0, shift_tx=0, tx_hold=0.
  - rx_data=0, rx_valid=0, frame_err=0, led=0.
  - Synchroniser flops reset to cs=1, sclk=0, mosi=0.
  - Reset mid-frame discards partial data with no frame_err pulse.
- Synchronisation and edge detection:
  - cs, sclk and mosi each pass through SYNC_STAGES flops.
  - Edges are detected by comparing the last stage with one extra delayed flop.
  - Edges: sclk_rise, sclk_fall, cs_fall, cs_rise.
- State machine, evaluated every sys_clk:
  - IDLE: on cs_fall, load shift_tx<=tx_hold, set bit_cnt=0, go to SHIFT.
  - SHIFT, on sclk_rise:
    - shift_rx<={shift_rx[REG_WIDTH-2:0], mosi_s}; bit_cnt++.
    - If bit_cnt becomes REG_WIDTH, go to DONE.
  - SHIFT, on sclk_fall: shift_tx<={shift_tx[REG_WIDTH-2:0],1'b0}, except when bit_cnt==0 (first bit stays on the line).
  - SHIFT, on cs_rise with bit_cnt!=0: frame_err=1 for one cycle, shift_rx discarded, go to IDLE.
  - SHIFT, on cs_rise with bit_cnt==0: go to IDLE silently.
  - DONE (one cycle):
    - rx_data<=shift_rx; rx_valid=1; led<=shift_rx[LED_WIDTH-1:0].
    - bit_cnt=0; shift_tx<=tx_hold.
    - If cs_s still low, go to SHIFT (back-to-back bytes in one frame); else go to IDLE.
- Latency: rx_valid rises exactly SYNC_STAGES+2 sys_clk cycles after the sys_clk edge that first sees the 8th sclk rise at the pin.
- miso = cs_s ? 1'bz : shift_tx[REG_WIDTH-1]. Tri-state control uses synchronised cs, so release lags the cs pin by SYNC_STAGES cycles.
- tx_load:
  - Updates tx_hold in any state.
  - Does not disturb an in-flight shift_tx.
  - If tx_load and a load into shift_tx coincide in the same cycle, the old tx_hold value is used.
- Simultaneous cs_rise and 8th sclk_rise in the same cycle: the bit is captured and the byte completes normally (DONE, no frame_err), then the block goes to IDLE.
- bit_cnt is $clog2(REG_WIDTH)+1 bits wide and cannot wrap.
- sclk edges seen while in IDLE are ignored.

Decomposition:
- Package spi_pkg:
  - State encoding IDLE=0, SHIFT=1, DONE=2 (2-bit).
  - Default REG_WIDTH and the shared mode-0 constants CPOL=0, CPHA=0, also used by the initiator.
- One natural sub-module, spi_sync_edge:
  - Parameterised SYNC_STAGES synchroniser plus rise/fall detector.
  - Instantiated three times (cs, sclk, mosi; mosi leaves the edge outputs unused).

Test Plan:
- Basic byte: reset, tx_load tx_data=8'hA5, then initiator sends 8'h3B MSB-first. Expect rx_valid pulse once, rx_data=8'h3B, led=6'h3B, miso bits 1,0,1,0,0,1,0,1.
- Back-to-back: one cs-low frame carries 8'h01 then 8'h20. Expect two rx_valid pulses, final led=6'h20, second miso byte = tx_hold loaded before the first DONE.
- Aborted frame: cs rises after 5 bits of 8'hFF. Expect frame_err=1 for one cycle, no rx_valid, rx_data and led unchanged, state IDLE.
- Reset mid-frame: rstn low for 2 cycles after 3 bits. Expect led=0, rx_data=0, miso=z, no frame_err; next full frame 8'h15 gives led=6'h15.
- Tri-state and idle noise: sclk toggles 10 times with cs high. Expect miso=z, no rx_valid, no frame_err.
- Ratio limit: sclk at exactly sys_clk/4 with random bytes (100 frames). Expect every rx_data to match the sent byte and every miso byte to match tx_hold.
